// File: rtl/ez90_mem_arb_if.sv
// Request/response bus of the eZ90 P7 memory arbiter: load and store issue queues,
// the single core memory port, and the return paths to each requester.
interface ez90_mem_arb_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
);
  logic              ld_req_valid;
  logic              ld_req_ready;
  logic [ADDR_W-1:0] ld_req_addr;
  logic [TAG_W-1:0]  ld_req_tag;

  logic              st_req_valid;
  logic              st_req_ready;
  logic [ADDR_W-1:0] st_req_addr;
  logic [DATA_W-1:0] st_req_data;
  logic [TAG_W-1:0]  st_req_tag;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  logic              ld_rsp_valid;
  logic [DATA_W-1:0] ld_rsp_data;
  logic [TAG_W-1:0]  ld_rsp_tag;
  logic              st_ack_valid;
  logic [TAG_W-1:0]  st_ack_tag;

  // Arbiter side.
  modport master (
    input  ld_req_valid, ld_req_addr, ld_req_tag,
    output ld_req_ready,
    input  st_req_valid, st_req_addr, st_req_data, st_req_tag,
    output st_req_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output ld_rsp_valid, ld_rsp_data, ld_rsp_tag,
    output st_ack_valid, st_ack_tag
  );

  // Requester and memory side.
  modport slave (
    output ld_req_valid, ld_req_addr, ld_req_tag,
    input  ld_req_ready,
    output st_req_valid, st_req_addr, st_req_data, st_req_tag,
    input  st_req_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  ld_rsp_valid, ld_rsp_data, ld_rsp_tag,
    input  st_ack_valid, st_ack_tag
  );
endinterface

// File: rtl/ez90_mem_arb.sv
// Round-robin load/store arbiter driving the single memory port with one outstanding
// transaction; flush drops pending load responses but never disturbs the bus protocol.
module ez90_mem_arb #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          busy,
  ez90_mem_arb_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  localparam logic OwnLd = 1'b0;
  localparam logic OwnSt = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              we_q, we_d;
  logic              drop_q, drop_d;
  logic              last_grant_q, last_grant_d;

  logic ld_ok, grant_ld, grant_st, rsp_fire;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tag_d        = tag_q;
    we_d         = we_q;
    drop_d       = drop_q;
    last_grant_d = last_grant_q;
    ld_ok        = 1'b0;
    grant_ld     = 1'b0;
    grant_st     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A flushed load is invisible to arbitration, so it cannot consume a turn.
        ld_ok    = bus.ld_req_valid && !flush;
        grant_st = bus.st_req_valid && (!ld_ok || (last_grant_q == OwnLd));
        grant_ld = ld_ok && !grant_st;
        if (grant_st) begin
          state_d      = StReq;
          owner_d      = OwnSt;
          last_grant_d = OwnSt;
          addr_d       = bus.st_req_addr;
          wdata_d      = bus.st_req_data;
          tag_d        = bus.st_req_tag;
          we_d         = 1'b1;
          drop_d       = 1'b0;
        end else if (grant_ld) begin
          state_d      = StReq;
          owner_d      = OwnLd;
          last_grant_d = OwnLd;
          addr_d       = bus.ld_req_addr;
          wdata_d      = '0;
          tag_d        = bus.ld_req_tag;
          we_d         = 1'b0;
          drop_d       = 1'b0;
        end
      end
      StReq: begin
        if (bus.mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (bus.mem_rsp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && (owner_q == OwnLd) && flush) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnLd;
      addr_q       <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
      we_q         <= 1'b0;
      drop_q       <= 1'b0;
      last_grant_q <= OwnSt;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      we_q         <= we_d;
      drop_q       <= drop_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grants are combinational from requester valids, so hold them off while in reset.
  assign bus.ld_req_ready  = rst_n && grant_ld;
  assign bus.st_req_ready  = rst_n && grant_st;

  assign bus.mem_req_valid = (state_q == StReq);
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;

  assign rsp_fire          = (state_q == StWait) && bus.mem_rsp_valid;
  assign bus.st_ack_valid  = rsp_fire && (owner_q == OwnSt);
  assign bus.st_ack_tag    = bus.st_ack_valid ? tag_q : '0;
  assign bus.ld_rsp_valid  = rsp_fire && (owner_q == OwnLd) && !drop_q && !flush;
  assign bus.ld_rsp_data   = bus.ld_rsp_valid ? bus.mem_rsp_rdata : '0;
  assign bus.ld_rsp_tag    = bus.ld_rsp_valid ? tag_q : '0;

  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_ez90_mem_arb.sv
// Directed self-checking bench for ez90_mem_arb: reset, lone load, round-robin,
// request stall, flush handling and reset mid-transaction.
module tb_ez90_mem_arb;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  ez90_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  ez90_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    flush = 1'b0;
    bus.ld_req_valid = 1'b0; bus.ld_req_addr = '0; bus.ld_req_tag = '0;
    bus.st_req_valid = 1'b0; bus.st_req_addr = '0; bus.st_req_data = '0; bus.st_req_tag = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Drives a lone load through IDLE and REQ, leaving the DUT in WAIT (no checks here).
  task automatic load_to_wait(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = a; bus.ld_req_tag = t;
    cyc();
    bus.ld_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    clr_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      flush = 1'($urandom);
      bus.ld_req_valid = 1'($urandom); bus.ld_req_addr = 24'($urandom);
      bus.ld_req_tag = 4'($urandom);
      bus.st_req_valid = 1'($urandom); bus.st_req_addr = 24'($urandom);
      bus.st_req_data = $urandom; bus.st_req_tag = 4'($urandom);
      bus.mem_req_ready = 1'($urandom); bus.mem_rsp_valid = 1'($urandom);
      bus.mem_rsp_rdata = $urandom;
      #1;
      outs = {bus.ld_req_ready, bus.st_req_ready, bus.mem_req_valid, bus.mem_req_we,
              bus.mem_req_addr, bus.mem_req_wdata, bus.ld_rsp_valid, bus.ld_rsp_data,
              bus.ld_rsp_tag, bus.st_ack_valid, bus.st_ack_tag, busy};
      n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_outs[%0d]: got %h want 0", i, outs); end
      cyc();
    end
    n_cmp++; if (bus.ld_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready: got %b want 0", bus.ld_req_ready); end
    n_cmp++; if (bus.mem_req_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.mem_req_addr); end
    clr_inputs();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_release: got %b want 0", busy); end
    cyc();
  endtask

  task automatic test_lone_load();
    do_reset();
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 24'h001234; bus.ld_req_tag = 4'd3;
    #1;
    n_cmp++; if ({bus.ld_req_ready, bus.st_req_ready, bus.mem_req_valid} !== 3'b100) begin n_err++; $display("FAIL lone_c0_ready: got %b want 100", {bus.ld_req_ready, bus.st_req_ready, bus.mem_req_valid}); end
    cyc();
    bus.ld_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_err++; $display("FAIL lone_c1_valid: got %b want 1", bus.mem_req_valid); end
    n_cmp++; if (bus.mem_req_we !== 1'b0) begin n_err++; $display("FAIL lone_c1_we: got %b want 0", bus.mem_req_we); end
    n_cmp++; if (bus.mem_req_addr !== 24'h001234) begin n_err++; $display("FAIL lone_c1_addr: got %h want 001234", bus.mem_req_addr); end
    n_cmp++; if (bus.mem_req_wdata !== 32'h0) begin n_err++; $display("FAIL lone_c1_wdata: got %h want 0", bus.mem_req_wdata); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lone_c1_busy: got %b want 1", busy); end
    cyc();
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL lone_c2_valid: got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (bus.ld_rsp_valid !== 1'b1) begin n_err++; $display("FAIL lone_c2_rsp_valid: got %b want 1", bus.ld_rsp_valid); end
    n_cmp++; if (bus.ld_rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL lone_c2_data: got %h want deadbeef", bus.ld_rsp_data); end
    n_cmp++; if (bus.ld_rsp_tag !== 4'd3) begin n_err++; $display("FAIL lone_c2_tag: got %h want 3", bus.ld_rsp_tag); end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({busy, bus.ld_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL lone_c3_idle: got %b want 00", {busy, bus.ld_rsp_valid}); end
  endtask

  task automatic test_round_robin();
    int nl = 0;
    int ns = 0;
    logic exp_st;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [TAG_W-1:0] e_tag;
    do_reset();
    bus.ld_req_valid = 1'b1; bus.st_req_valid = 1'b1; bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_st = (i % 2) == 1;
      bus.ld_req_addr = 24'(32'h100 + nl); bus.ld_req_tag = 4'(nl);
      bus.st_req_addr = 24'(32'h200 + ns); bus.st_req_data = 32'hA5000000 + ns;
      bus.st_req_tag = 4'(8 + ns);
      e_addr  = exp_st ? 24'(32'h200 + ns) : 24'(32'h100 + nl);
      e_wdata = exp_st ? 32'hA5000000 + ns : 32'h0;
      e_tag   = exp_st ? 4'(8 + ns) : 4'(nl);
      #1;
      n_cmp++; if ({bus.ld_req_ready, bus.st_req_ready} !== {!exp_st, exp_st}) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {bus.ld_req_ready, bus.st_req_ready}, {!exp_st, exp_st}); end
      cyc();
      #1;
      n_cmp++; if ({bus.mem_req_valid, bus.mem_req_we} !== {1'b1, exp_st}) begin n_err++; $display("FAIL rr_we[%0d]: got %b want %b", i, {bus.mem_req_valid, bus.mem_req_we}, {1'b1, exp_st}); end
      n_cmp++; if ({bus.mem_req_addr, bus.mem_req_wdata} !== {e_addr, e_wdata}) begin n_err++; $display("FAIL rr_payload[%0d]: got %h/%h want %h/%h", i, bus.mem_req_addr, bus.mem_req_wdata, e_addr, e_wdata); end
      n_cmp++; if ({bus.ld_req_ready, bus.st_req_ready} !== 2'b00) begin n_err++; $display("FAIL rr_ready_req[%0d]: got %b want 00", i, {bus.ld_req_ready, bus.st_req_ready}); end
      cyc();
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hC0DE0000 + i;
      #1;
      if (exp_st) begin
        n_cmp++; if ({bus.st_ack_valid, bus.st_ack_tag, bus.ld_rsp_valid} !== {1'b1, e_tag, 1'b0}) begin n_err++; $display("FAIL rr_ack[%0d]: got %b/%h/%b want 1/%h/0", i, bus.st_ack_valid, bus.st_ack_tag, bus.ld_rsp_valid, e_tag); end
        ns++;
      end else begin
        n_cmp++; if ({bus.ld_rsp_valid, bus.ld_rsp_tag, bus.st_ack_valid} !== {1'b1, e_tag, 1'b0}) begin n_err++; $display("FAIL rr_ldrsp[%0d]: got %b/%h/%b want 1/%h/0", i, bus.ld_rsp_valid, bus.ld_rsp_tag, bus.st_ack_valid, e_tag); end
        n_cmp++; if (bus.ld_rsp_data !== 32'hC0DE0000 + i) begin n_err++; $display("FAIL rr_lddata[%0d]: got %h want %h", i, bus.ld_rsp_data, 32'hC0DE0000 + i); end
        nl++;
      end
      cyc();
      bus.mem_rsp_valid = 1'b0;
    end
    clr_inputs();
  endtask

  task automatic test_store_stall();
    do_reset();
    bus.st_req_valid = 1'b1; bus.st_req_addr = 24'h00ABCD;
    bus.st_req_data = 32'h12345678; bus.st_req_tag = 4'd5;
    #1;
    n_cmp++; if (bus.st_req_ready !== 1'b1) begin n_err++; $display("FAIL stall_grant: got %b want 1", bus.st_req_ready); end
    cyc();
    bus.st_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_req_ready = (i == 3);
      #1;
      n_cmp++; if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata} !== {1'b1, 1'b1, 24'h00ABCD, 32'h12345678}) begin n_err++; $display("FAIL stall_hold[%0d]: got %b/%b/%h/%h want 1/1/00abcd/12345678", i, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata); end
      cyc();
    end
    bus.mem_req_ready = 1'b0;
    #1;
    n_cmp++; if ({bus.mem_req_valid, busy, bus.st_ack_valid} !== 3'b010) begin n_err++; $display("FAIL stall_wait: got %b want 010", {bus.mem_req_valid, busy, bus.st_ack_valid}); end
    cyc();
    bus.mem_rsp_valid = 1'b1;
    #1;
    n_cmp++; if ({bus.st_ack_valid, bus.st_ack_tag} !== {1'b1, 4'd5}) begin n_err++; $display("FAIL stall_ack: got %b/%h want 1/5", bus.st_ack_valid, bus.st_ack_tag); end
    cyc();
    clr_inputs();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b want 0", busy); end
  endtask

  task automatic test_flush();
    do_reset();
    // Flush in IDLE with both sides valid: load suppressed, store granted; flush held
    // throughout the store.
    flush = 1'b1;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 24'h000777; bus.ld_req_tag = 4'd1;
    bus.st_req_valid = 1'b1; bus.st_req_addr = 24'h000888; bus.st_req_data = 32'h55AA55AA;
    bus.st_req_tag = 4'd9;
    #1;
    n_cmp++; if ({bus.ld_req_ready, bus.st_req_ready} !== 2'b01) begin n_err++; $display("FAIL flush_idle_grant: got %b want 01", {bus.ld_req_ready, bus.st_req_ready}); end
    cyc();
    bus.ld_req_valid = 1'b0; bus.st_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++; if ({bus.mem_req_valid, bus.mem_req_we} !== 2'b11) begin n_err++; $display("FAIL flush_st_req: got %b want 11", {bus.mem_req_valid, bus.mem_req_we}); end
    cyc();
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1;
    #1;
    n_cmp++; if ({bus.st_ack_valid, bus.st_ack_tag} !== {1'b1, 4'd9}) begin n_err++; $display("FAIL flush_st_ack: got %b/%h want 1/9", bus.st_ack_valid, bus.st_ack_tag); end
    cyc();
    clr_inputs();

    // Flush in WAIT before the response arrives.
    load_to_wait(24'h000321, 4'd6);
    flush = 1'b1;
    #1;
    cyc();
    flush = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h11112222;
    #1;
    n_cmp++; if (bus.ld_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_wait_drop: got %b want 0", bus.ld_rsp_valid); end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_wait_idle: got %b want 0", busy); end

    // Flush in the same cycle as the response.
    load_to_wait(24'h000654, 4'd7);
    flush = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h33334444;
    #1;
    n_cmp++; if (bus.ld_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_same_drop: got %b want 0", bus.ld_rsp_valid); end
    cyc();
    clr_inputs();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_same_idle: got %b want 0", busy); end

    // A fresh load after a dropped one is delivered normally.
    load_to_wait(24'h000999, 4'd2);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h0BADF00D;
    #1;
    n_cmp++; if ({bus.ld_rsp_valid, bus.ld_rsp_tag, bus.ld_rsp_data} !== {1'b1, 4'd2, 32'h0BADF00D}) begin n_err++; $display("FAIL flush_after_load: got %b/%h/%h want 1/2/0badf00d", bus.ld_rsp_valid, bus.ld_rsp_tag, bus.ld_rsp_data); end
    cyc();
    clr_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    load_to_wait(24'h000abc, 4'd4);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_in_wait: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_async: got %b want 0", busy); end
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hFEEDFACE;
    #1;
    n_cmp++; if ({bus.ld_rsp_valid, bus.st_ack_valid, busy} !== 3'b000) begin n_err++; $display("FAIL midrst_stale_rsp: got %b want 000", {bus.ld_rsp_valid, bus.st_ack_valid, busy}); end
    cyc();
    bus.mem_rsp_valid = 1'b0;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 24'h000def; bus.ld_req_tag = 4'd12;
    #1;
    n_cmp++; if (bus.ld_req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_regrant: got %b want 1", bus.ld_req_ready); end
    cyc();
    bus.ld_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 24'h000def}) begin n_err++; $display("FAIL midrst_req: got %b/%h want 1/000def", bus.mem_req_valid, bus.mem_req_addr); end
    cyc();
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h600DCAFE;
    #1;
    n_cmp++; if ({bus.ld_rsp_valid, bus.ld_rsp_tag, bus.ld_rsp_data} !== {1'b1, 4'd12, 32'h600DCAFE}) begin n_err++; $display("FAIL midrst_rsp: got %b/%h/%h want 1/c/600dcafe", bus.ld_rsp_valid, bus.ld_rsp_tag, bus.ld_rsp_data); end
    cyc();
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_load();
    test_round_robin();
    test_store_stall();
    test_flush();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
